// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, register-index width and the x0 register constant.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] X0 = '0;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MDU_BUSY = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
// Purely combinational load-use hazard compare between the instruction in
// ID and a load sitting in EX.
// Ports:
//   rs1, rs2           source registers of the ID instruction
//   uses_rs1, uses_rs2 ID instruction actually reads rs1 / rs2
//   ex_mem_read        instruction in EX is a load
//   ex_rd              destination register of the EX instruction
//   hazard             a one-cycle bubble is required
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic                 uses_rs1,
  input  logic                 uses_rs2,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 hazard
);

  // Loads into x0 are discarded, so they can never feed a dependent.
  assign hazard = ex_mem_read && (ex_rd != X0) &&
                  ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush controller for the 5-stage pipeline. Generates all pipeline
// register write enables and flushes for load-use bubbles, taken-branch
// redirects, multi-cycle MDU sequencing and data-memory wait states, and
// keeps a saturating count of cycles in which the PC was held.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   ID_rs1_i, ID_rs2_i               ID source registers
//   ID_uses_rs1_i, ID_uses_rs2_i     ID instruction reads rs1 / rs2
//   ID_EX_MemRead_i, ID_EX_rd_i      EX instruction is a load / its rd
//   EX_is_mdu_i, mdu_done_i          EX is MUL/DIV/REM, MDU result valid
//   EX_branch_taken_i                taken branch/jump resolved in EX
//   dmem_req_i, dmem_ready_i         MEM access active / completing
//   *_write_o                        pipeline register enables
//   *_flush_o                        bubble insertion
//   mdu_start_o                      one-cycle MDU launch pulse
//   stall_cnt_o                      saturating count of PC-held cycles
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REG_IDX_W-1:0] ID_rs1_i,
  input  logic [REG_IDX_W-1:0] ID_rs2_i,
  input  logic                 ID_uses_rs1_i,
  input  logic                 ID_uses_rs2_i,
  input  logic                 ID_EX_MemRead_i,
  input  logic [REG_IDX_W-1:0] ID_EX_rd_i,
  input  logic                 EX_is_mdu_i,
  input  logic                 mdu_done_i,
  input  logic                 EX_branch_taken_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ready_i,
  output logic                 PC_write_o,
  output logic                 IF_ID_write_o,
  output logic                 ID_EX_write_o,
  output logic                 EX_MEM_write_o,
  output logic                 IF_ID_flush_o,
  output logic                 ID_EX_flush_o,
  output logic                 EX_MEM_flush_o,
  output logic                 MEM_WB_flush_o,
  output logic                 mdu_start_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  logic [1:0] state, next_state;
  logic [1:0] ret_state, next_ret;
  logic [1:0] eff_state;
  logic       mem_wait;
  logic       load_use;
  logic       hold_front;
  logic       allow_id;

  load_use_detect u_lud (
    .rs1         (ID_rs1_i),
    .rs2         (ID_rs2_i),
    .uses_rs1    (ID_uses_rs1_i),
    .uses_rs2    (ID_uses_rs2_i),
    .ex_mem_read (ID_EX_MemRead_i),
    .ex_rd       (ID_EX_rd_i),
    .hazard      (load_use)
  );

  assign mem_wait = dmem_req_i && !dmem_ready_i;

  // When a memory wait resolves, this cycle is decoded as the state that
  // was interrupted.
  assign eff_state = (state == ST_MEM_WAIT) ? ret_state : state;

  always_comb begin
    PC_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    ID_EX_write_o  = 1'b1;
    EX_MEM_write_o = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_flush_o  = 1'b0;
    EX_MEM_flush_o = 1'b0;
    MEM_WB_flush_o = 1'b0;
    mdu_start_o    = 1'b0;
    next_state     = state;
    next_ret       = ret_state;
    hold_front     = 1'b0;
    allow_id       = 1'b0;

    if (rst_i) begin
      PC_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      ID_EX_write_o  = 1'b0;
      EX_MEM_write_o = 1'b0;
      IF_ID_flush_o  = 1'b1;
      ID_EX_flush_o  = 1'b1;
      EX_MEM_flush_o = 1'b1;
      MEM_WB_flush_o = 1'b1;
      next_state     = ST_RUN;
      next_ret       = ST_RUN;
    end else if (mem_wait) begin
      // Whole pipeline frozen; only the access in MEM is kept out of WB.
      PC_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      ID_EX_write_o  = 1'b0;
      EX_MEM_write_o = 1'b0;
      MEM_WB_flush_o = 1'b1;
      next_state     = ST_MEM_WAIT;
      next_ret       = (state == ST_MEM_WAIT) ? ret_state : state;
    end else begin
      if (eff_state == ST_MDU_BUSY) begin
        if (mdu_done_i) begin
          next_state = ST_RUN;
          allow_id   = 1'b1;
        end else begin
          hold_front = 1'b1;
          next_state = ST_MDU_BUSY;
        end
      end else begin
        next_state = ST_RUN;
        if (EX_is_mdu_i) begin
          mdu_start_o = 1'b1;
          hold_front  = 1'b1;
          next_state  = ST_MDU_BUSY;
        end else begin
          allow_id = 1'b1;
        end
      end

      if (hold_front) begin
        // MDU op stays in EX; a bubble goes forward into MEM.
        PC_write_o     = 1'b0;
        IF_ID_write_o  = 1'b0;
        ID_EX_write_o  = 1'b0;
        EX_MEM_flush_o = 1'b1;
      end else if (allow_id) begin
        if (EX_branch_taken_i) begin
          IF_ID_flush_o = 1'b1;
          ID_EX_flush_o = 1'b1;
        end else if (load_use) begin
          PC_write_o    = 1'b0;
          IF_ID_write_o = 1'b0;
          ID_EX_flush_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_RUN;
      ret_state   <= ST_RUN;
      stall_cnt_o <= '0;
    end else begin
      state     <= next_state;
      ret_state <= next_ret;
      if (!PC_write_o && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       uses_rs1, uses_rs2, ex_memread, ex_is_mdu, mdu_done;
  logic       br_taken, dmem_req, dmem_ready;

  logic        pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, memwb_f, start;
  logic [15:0] cnt;
  logic        s_pc_w, s_ifid_w, s_idex_w, s_exmem_w, s_ifid_f, s_idex_f, s_exmem_f, s_memwb_f, s_start;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  // {PC, IF_ID, ID_EX, EX_MEM writes, IF_ID, ID_EX, EX_MEM, MEM_WB flushes, start}
  localparam logic [8:0] O_DEF  = 9'b1111_0000_0;
  localparam logic [8:0] O_RST  = 9'b0000_1111_0;
  localparam logic [8:0] O_LU   = 9'b0011_0100_0;
  localparam logic [8:0] O_BR   = 9'b1111_1100_0;
  localparam logic [8:0] O_LAUN = 9'b0001_0010_1;
  localparam logic [8:0] O_HOLD = 9'b0001_0010_0;
  localparam logic [8:0] O_MEMW = 9'b0000_0001_0;

  wire [8:0] outs   = {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, memwb_f, start};
  wire [8:0] s_outs = {s_pc_w, s_ifid_w, s_idex_w, s_exmem_w, s_ifid_f, s_idex_f, s_exmem_f, s_memwb_f, s_start};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2),
    .ID_uses_rs1_i(uses_rs1), .ID_uses_rs2_i(uses_rs2),
    .ID_EX_MemRead_i(ex_memread), .ID_EX_rd_i(ex_rd),
    .EX_is_mdu_i(ex_is_mdu), .mdu_done_i(mdu_done),
    .EX_branch_taken_i(br_taken),
    .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
    .PC_write_o(pc_w), .IF_ID_write_o(ifid_w), .ID_EX_write_o(idex_w), .EX_MEM_write_o(exmem_w),
    .IF_ID_flush_o(ifid_f), .ID_EX_flush_o(idex_f), .EX_MEM_flush_o(exmem_f), .MEM_WB_flush_o(memwb_f),
    .mdu_start_o(start), .stall_cnt_o(cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst),
    .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2),
    .ID_uses_rs1_i(uses_rs1), .ID_uses_rs2_i(uses_rs2),
    .ID_EX_MemRead_i(ex_memread), .ID_EX_rd_i(ex_rd),
    .EX_is_mdu_i(ex_is_mdu), .mdu_done_i(mdu_done),
    .EX_branch_taken_i(br_taken),
    .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
    .PC_write_o(s_pc_w), .IF_ID_write_o(s_ifid_w), .ID_EX_write_o(s_idex_w), .EX_MEM_write_o(s_exmem_w),
    .IF_ID_flush_o(s_ifid_f), .ID_EX_flush_o(s_idex_f), .EX_MEM_flush_o(s_exmem_f), .MEM_WB_flush_o(s_memwb_f),
    .mdu_start_o(s_start), .stall_cnt_o(s_cnt)
  );

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; ex_memread = 1'b0;
    ex_is_mdu = 1'b0; mdu_done = 1'b0; br_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Leaves time at posedge+1 with reset released and inputs idle.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if (outs !== O_RST) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RST); end
    @(posedge clk); #1;
    checks++;
    if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL post_reset_default got=%b exp=%b", outs, O_DEF); end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; uses_rs1 = 1'b1;
    #1;
    checks++;
    if (outs !== O_LU) begin errors++; $display("FAIL lu_rs1 got=%b exp=%b", outs, O_LU); end
    next_cycle();
    ex_memread = 1'b0;
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL lu_one_bubble got=%b exp=%b", outs, O_DEF); end
    checks++;
    if (cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", cnt); end
    next_cycle();
    // rs1 matches but is unused, rs2 unused: no hazard
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; uses_rs1 = 1'b0; id_rs2 = 5'd7; uses_rs2 = 1'b0;
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL lu_unused got=%b exp=%b", outs, O_DEF); end
    uses_rs2 = 1'b1;
    #1;
    checks++;
    if (outs !== O_LU) begin errors++; $display("FAIL lu_rs2 got=%b exp=%b", outs, O_LU); end
    next_cycle();
    ex_rd = 5'd0; id_rs1 = 5'd0; uses_rs1 = 1'b1; id_rs2 = 5'd0;
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL lu_x0 got=%b exp=%b", outs, O_DEF); end
    next_cycle();
    checks++;
    if (cnt !== 16'd2) begin errors++; $display("FAIL lu_cnt_total got=%0d exp=2", cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; uses_rs1 = 1'b1; br_taken = 1'b1;
    #1;
    checks++;
    if (outs !== O_BR) begin errors++; $display("FAIL branch_over_lu got=%b exp=%b", outs, O_BR); end
    next_cycle();
    checks++;
    if (cnt !== 16'd0) begin errors++; $display("FAIL branch_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_mdu();
    do_reset();
    ex_is_mdu = 1'b1;
    #1;
    checks++;
    if (outs !== O_LAUN) begin errors++; $display("FAIL mdu_launch got=%b exp=%b", outs, O_LAUN); end
    next_cycle();
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++;
      if (outs !== O_HOLD) begin errors++; $display("FAIL mdu_hold c%0d got=%b exp=%b", i, outs, O_HOLD); end
      next_cycle();
    end
    mdu_done = 1'b1; br_taken = 1'b1;
    #1;
    checks++;
    if (outs !== O_BR) begin errors++; $display("FAIL mdu_release_branch got=%b exp=%b", outs, O_BR); end
    next_cycle();
    ex_is_mdu = 1'b0; br_taken = 1'b0;
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL mdu_done_ignored_run got=%b exp=%b", outs, O_DEF); end
    checks++;
    if (cnt !== 16'd4) begin errors++; $display("FAIL mdu_cnt got=%0d exp=4", cnt); end
    next_cycle();
  endtask

  task automatic test_mem_in_mdu();
    do_reset();
    ex_is_mdu = 1'b1;
    next_cycle();
    #1;
    checks++;
    if (outs !== O_HOLD) begin errors++; $display("FAIL mim_hold got=%b exp=%b", outs, O_HOLD); end
    next_cycle();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== O_MEMW) begin errors++; $display("FAIL mim_wait c%0d got=%b exp=%b", i, outs, O_MEMW); end
      next_cycle();
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== O_HOLD) begin errors++; $display("FAIL mim_release got=%b exp=%b", outs, O_HOLD); end
    next_cycle();
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    checks++;
    if (outs !== O_HOLD) begin errors++; $display("FAIL mim_back_in_mdu got=%b exp=%b", outs, O_HOLD); end
    next_cycle();
    mdu_done = 1'b1;
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL mim_done got=%b exp=%b", outs, O_DEF); end
    checks++;
    if (cnt !== 16'd7) begin errors++; $display("FAIL mim_cnt got=%0d exp=7", cnt); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_is_mdu = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    checks++;
    if (outs !== O_MEMW) begin errors++; $display("FAIL b2b_mem_over_mdu got=%b exp=%b", outs, O_MEMW); end
    next_cycle();
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== O_LAUN) begin errors++; $display("FAIL b2b_launch_after_wait got=%b exp=%b", outs, O_LAUN); end
    next_cycle();
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    checks++;
    if (outs !== O_HOLD) begin errors++; $display("FAIL b2b_no_second_start got=%b exp=%b", outs, O_HOLD); end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if (cnt !== 16'd2) begin errors++; $display("FAIL rmw_cnt_before got=%0d exp=2", cnt); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== O_RST) begin errors++; $display("FAIL rmw_async_outs got=%b exp=%b", outs, O_RST); end
    checks++;
    if (cnt !== 16'd0) begin errors++; $display("FAIL rmw_async_cnt got=%0d exp=0", cnt); end
    next_cycle();
    idle_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL rmw_after_release got=%b exp=%b", outs, O_DEF); end
    next_cycle();
    checks++;
    if (outs !== O_DEF || cnt !== 16'd0) begin
      errors++; $display("FAIL rmw_run_state got=%b cnt=%0d exp=%b cnt=0", outs, cnt, O_DEF);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 15; i++) next_cycle();
    checks++;
    if (s_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach got=%0d exp=15", s_cnt); end
    for (int i = 0; i < 5; i++) next_cycle();
    checks++;
    if (s_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", s_cnt); end
    checks++;
    if (cnt !== 16'd20) begin errors++; $display("FAIL sat_wide_cnt got=%0d exp=20", cnt); end
    checks++;
    if (s_outs !== O_MEMW) begin errors++; $display("FAIL sat_outs got=%b exp=%b", s_outs, O_MEMW); end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_mem_in_mdu();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
